// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: one main entry plus one skid entry so in_ready is a
// plain register decode, with synchronous flush-to-NOP and a saturating stall counter.
module pipe_stage_skid #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [31:0]       FLUSH_VAL = 32'h0000_0013,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  localparam logic [DATA_W+31:0] FLUSH_EXT = {{DATA_W{1'b0}}, FLUSH_VAL};
  localparam logic [DATA_W-1:0]  FLUSH_D   = FLUSH_EXT[DATA_W-1:0];

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              main_valid, skid_valid;
  logic              in_fire, out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign in_ready   = !skid_valid;
  assign out_valid  = main_valid;
  assign out_data   = main_q;
  assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt  = cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = FLUSH_D;
      skid_d  = FLUSH_D;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stall statistics run independently of flush.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_stats) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
